stream_mux_rr: RTL
==================

// Module: stream_mux_rr
// PURPOSE
//  Parametrised successor to the combinational 4:1 mux: an NCH-input, WIDTH-bit
//  stream multiplexer with valid/ready handshakes, packet locking on 'last',
//  a registered output stage and a run-time selectable mode (fixed select or
//  round-robin). Sits between several producer streams and one consumer.
// PARAMETERS
//  WIDTH  8  data bits per channel (true width, not width-1)
//  NCH    4  number of input channels, >=2
//  SW     2  select/channel-index width, must satisfy 2**SW >= NCH
// PORTS
//  clk        in   1          rising-edge clock, single clock domain
//  rst        in   1          asynchronous, active-high reset
//  rr_en      in   1          1 = round-robin arbitration, 0 = fixed select
//  s          in   SW         channel select used when rr_en=0
//  in_valid   in   NCH        per-channel valid
//  in_data    in   NCH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
//  in_last    in   NCH        per-channel end-of-packet marker
//  in_ready   out  NCH        per-channel ready
//  out_valid  out  1          output beat valid (registered)
//  out_data   out  WIDTH      output data (registered)
//  out_last   out  1          output end-of-packet (registered)
//  out_ch     out  SW         channel index the output beat came from
//  out_ready  in   1          consumer ready
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, grant=0, ptr=0, out_valid=0, out_data=0,
//   out_last=0, out_ch=0, in_ready=all 0. Any in-flight packet is dropped.
//  Transfer: a beat moves on any edge where valid&ready are both 1.
//  FSM IDLE: in_ready=0. rr_en and s are sampled only here.
//   rr_en=1: grant = first i with in_valid[i]=1, scanning ptr,ptr+1,..
//    wrapping mod NCH. rr_en=0: grant = s, only if s<NCH and in_valid[s]=1.
//   No candidate -> stay IDLE. Candidate -> store grant, go LOCKED next
//   edge (1-cycle arbitration bubble per packet).
//  FSM LOCKED: in_ready[grant] = (!out_valid | out_ready); all others 0.
//   Changes on rr_en, s or other in_valid are ignored until packet end.
//   Accepted beat loads out_data/out_last/out_ch=grant; out_valid=1 next cycle.
//   Accepting a beat with in_last=1 -> IDLE, ptr = (grant+1) mod NCH
//   (ptr updated in fixed mode too).
//  Output register: once out_valid=1, out_data/out_last/out_ch stay stable
//   until out_ready=1. out_valid clears after acceptance unless a new beat
//   is loaded on the same edge. Full throughput: 1 beat/cycle within a packet.
//  Latency: input accept at edge k -> out_valid=1 after edge k.
//  Simultaneous: out_ready=1 and new input accept on the same edge -> output
//   register is overwritten with the new beat; no bubble, no loss.
//  Single-beat packets: in_last=1 on first beat -> IDLE after 1 beat.
//  Grant is never withdrawn mid-packet, even if in_valid[grant] drops.
// TESTING
//  1 Reset: assert rst mid-packet (out_valid=1) -> out_valid, in_ready,
//    out_ch drop to 0 immediately; next packet arbitrates from ptr=0.
//  2 Fixed mode: rr_en=0, s=2, ch2 sends 3 beats 0xA1,0xA2,0xA3(last),
//    out_ready=1 -> out sees A1,A2,A3 consecutively, out_ch=2, out_last on A3.
//  3 Round-robin: rr_en=1, all 4 channels send 1-beat packets continuously ->
//    out_ch sequence 0,1,2,3,0,... with one idle cycle between packets.
//  4 Lock: ch1 mid-packet, ch0 raises valid and s switched to 0 -> ch1
//    packet completes uninterrupted; ch0 served only after ch1 last.
//  5 Backpressure: out_ready=0 for 5 cycles during a packet -> out_data held
//    stable, in_ready[grant]=0; resume -> no beats lost or duplicated.
//  6 Bad select: rr_en=0, s=5 with NCH=4 (SW=3) -> stays IDLE, in_ready=0.

Source files
------------

// File: rtl/stream_mux_rr_if.sv
// Stream bundle for stream_mux_rr: NCH producer lanes in, one consumer lane out.
interface stream_mux_rr_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SW    = 2
);
    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_last;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic                 out_last;
    logic [SW-1:0]        out_ch;
    logic                 out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ch
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// NCH:1 packet-locking stream mux, fixed-select or round-robin,
// with a registered output stage.
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rr_en,
    input  logic [SW-1:0] s,
    stream_mux_rr_if.slave bus
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state;
    logic [SW-1:0]    grant;
    logic [SW-1:0]    ptr;
    logic [SW-1:0]    ptr_nxt;
    logic [SW-1:0]    cand;
    logic             cand_ok;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic             open;
    logic             acc;

    assign open    = !bus.out_valid || bus.out_ready;
    assign acc     = |(bus.in_valid & bus.in_ready);
    assign ptr_nxt = (grant == SW'(NCH-1)) ? '0 : grant + 1'b1;

    // Round-robin scans ptr..NCH-1 first, then wraps to 0..ptr-1.
    always_comb begin
        cand_ok = 1'b0;
        cand    = '0;
        if (rr_en) begin
            for (int i = 0; i < NCH; i++) begin
                if (!cand_ok && bus.in_valid[i] && SW'(i) >= ptr) begin
                    cand_ok = 1'b1;
                    cand    = SW'(i);
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (!cand_ok && bus.in_valid[i] && SW'(i) < ptr) begin
                    cand_ok = 1'b1;
                    cand    = SW'(i);
                end
            end
        end else begin
            // Out-of-range selects match no channel and leave the mux idle.
            for (int i = 0; i < NCH; i++) begin
                if (bus.in_valid[i] && SW'(i) == s) begin
                    cand_ok = 1'b1;
                    cand    = s;
                end
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        sel_data     = '0;
        sel_last     = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (SW'(i) == grant) begin
                sel_data        = bus.in_data[i*WIDTH +: WIDTH];
                sel_last        = bus.in_last[i];
                bus.in_ready[i] = (state == LOCKED) && open;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= '0;
            ptr           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.out_ch    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cand_ok) begin
                        grant <= cand;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (acc && sel_last) begin
                        state <= IDLE;
                        ptr   <= ptr_nxt;
                    end
                end
                default: state <= IDLE;
            endcase

            if (acc) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= sel_data;
                bus.out_last  <= sel_last;
                bus.out_ch    <= grant;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule
